// File: rtl/csr_unit.sv
// csr_unit -- machine-mode CSR file with trap entry / MRET handling.
//
// Implements mstatus (MIE/MPIE, MPP hardwired to 11), mtvec, mscratch,
// mepc, mcause and a read-only zero mhartid. Trap entry has priority over
// MRET, which has priority over a software CSR write; a lower-priority
// action in the same cycle is dropped.
//
// Optional feature: define CSR_COUNTERS_EN to add 64-bit mcycle
// (0xB00/0xB80) and minstret (0xB02/0xB82). Without it those addresses
// are unmapped and instr_retire is ignored.
//
// Ports:
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   trap_entry      save trap context this cycle (trap_pc, mcause_in)
//   mret_sig        return from trap: MIE <= MPIE, MPIE <= 1
//   csr_we/op/addr  CSR access strobe, op (00 none/01 RW/10 RS/11 RC), address
//   csr_wdata       write value or set/clear mask
//   instr_retire    one instruction retired this cycle (minstret)
//   csr_rdata       combinational read of csr_addr (0 when unmapped)
//   mtvec_out       registered trap vector
//   mepc_out        registered return PC
//   mie_out         registered mstatus.MIE
//   csr_illegal     combinational: current access is illegal
module csr_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        trap_entry,
  input  logic [31:0] trap_pc,
  input  logic [3:0]  mcause_in,
  input  logic        mret_sig,
  input  logic        csr_we,
  input  logic [1:0]  csr_op,
  input  logic [11:0] csr_addr,
  input  logic [31:0] csr_wdata,
  input  logic        instr_retire,
  output logic [31:0] csr_rdata,
  output logic [31:0] mtvec_out,
  output logic [31:0] mepc_out,
  output logic        mie_out,
  output logic        csr_illegal
);

  localparam logic [11:0] A_MSTATUS  = 12'h300;
  localparam logic [11:0] A_MTVEC    = 12'h305;
  localparam logic [11:0] A_MSCRATCH = 12'h340;
  localparam logic [11:0] A_MEPC     = 12'h341;
  localparam logic [11:0] A_MCAUSE   = 12'h342;
  localparam logic [11:0] A_MHARTID  = 12'hF14;
`ifdef CSR_COUNTERS_EN
  localparam logic [11:0] A_MCYCLE    = 12'hB00;
  localparam logic [11:0] A_MCYCLEH   = 12'hB80;
  localparam logic [11:0] A_MINSTRET  = 12'hB02;
  localparam logic [11:0] A_MINSTRETH = 12'hB82;
`endif

  localparam logic [1:0] OP_NONE = 2'b00;
  localparam logic [1:0] OP_RW   = 2'b01;
  localparam logic [1:0] OP_RS   = 2'b10;
  localparam logic [1:0] OP_RC   = 2'b11;

  logic        mie_q,      mie_d;
  logic        mpie_q,     mpie_d;
  logic [31:0] mtvec_q,    mtvec_d;
  logic [31:0] mscratch_q, mscratch_d;
  logic [31:0] mepc_q,     mepc_d;
  logic [3:0]  mcause_q,   mcause_d;
`ifdef CSR_COUNTERS_EN
  logic [63:0] mcycle_q,   mcycle_d;
  logic [63:0] minstret_q, minstret_d;
`else
  logic        unused_retire;
  assign unused_retire = instr_retire;
`endif

  logic [31:0] rd_val;
  logic        mapped;
  logic [31:0] wr_val;
  logic        wr_en;

  // Read decode: value of the addressed CSR, plus whether it exists.
  always_comb begin
    rd_val = 32'h0;
    mapped = 1'b1;
    case (csr_addr)
      A_MSTATUS:   rd_val = {19'b0, 2'b11, 3'b0, mpie_q, 3'b0, mie_q, 3'b0};
      A_MTVEC:     rd_val = mtvec_q;
      A_MSCRATCH:  rd_val = mscratch_q;
      A_MEPC:      rd_val = mepc_q;
      A_MCAUSE:    rd_val = {28'b0, mcause_q};
      A_MHARTID:   rd_val = 32'h0;
`ifdef CSR_COUNTERS_EN
      A_MCYCLE:    rd_val = mcycle_q[31:0];
      A_MCYCLEH:   rd_val = mcycle_q[63:32];
      A_MINSTRET:  rd_val = minstret_q[31:0];
      A_MINSTRETH: rd_val = minstret_q[63:32];
`endif
      default:     mapped = 1'b0;
    endcase
  end

  assign csr_rdata   = rd_val;
  assign csr_illegal = csr_we &&
                       (!mapped || (csr_addr == A_MHARTID && csr_op != OP_NONE));

  // Read-modify-write operand for RW / RS / RC.
  always_comb begin
    case (csr_op)
      OP_RW:   wr_val = csr_wdata;
      OP_RS:   wr_val = rd_val | csr_wdata;
      OP_RC:   wr_val = rd_val & ~csr_wdata;
      default: wr_val = rd_val;
    endcase
  end

  // A software write only lands when no trap or MRET claims the cycle.
  assign wr_en = csr_we && (csr_op != OP_NONE) && !csr_illegal &&
                 !trap_entry && !mret_sig;

  always_comb begin
    mie_d      = mie_q;
    mpie_d     = mpie_q;
    mtvec_d    = mtvec_q;
    mscratch_d = mscratch_q;
    mepc_d     = mepc_q;
    mcause_d   = mcause_q;

    if (trap_entry) begin
      mepc_d   = trap_pc & ~32'h3;
      mcause_d = mcause_in;
      mpie_d   = mie_q;
      mie_d    = 1'b0;
    end else if (mret_sig) begin
      mie_d  = mpie_q;
      mpie_d = 1'b1;
    end else if (wr_en) begin
      case (csr_addr)
        A_MSTATUS: begin
          mie_d  = wr_val[3];
          mpie_d = wr_val[7];
        end
        A_MTVEC:    mtvec_d    = wr_val & ~32'h3;
        A_MSCRATCH: mscratch_d = wr_val;
        A_MEPC:     mepc_d     = wr_val & ~32'h3;
        A_MCAUSE:   mcause_d   = wr_val[3:0];
        default: ;
      endcase
    end
  end

`ifdef CSR_COUNTERS_EN
  // Counters always advance; a write to one half overrides only that half.
  always_comb begin
    mcycle_d   = mcycle_q + 64'd1;
    minstret_d = minstret_q + {63'd0, instr_retire};
    if (wr_en) begin
      case (csr_addr)
        A_MCYCLE:    mcycle_d[31:0]    = wr_val;
        A_MCYCLEH:   mcycle_d[63:32]   = wr_val;
        A_MINSTRET:  minstret_d[31:0]  = wr_val;
        A_MINSTRETH: minstret_d[63:32] = wr_val;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcycle_q   <= 64'd0;
      minstret_q <= 64'd0;
    end else begin
      mcycle_q   <= mcycle_d;
      minstret_q <= minstret_d;
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mie_q      <= 1'b0;
      mpie_q     <= 1'b0;
      mtvec_q    <= 32'h0000_0100;
      mscratch_q <= 32'h0;
      mepc_q     <= 32'h0;
      mcause_q   <= 4'h0;
    end else begin
      mie_q      <= mie_d;
      mpie_q     <= mpie_d;
      mtvec_q    <= mtvec_d;
      mscratch_q <= mscratch_d;
      mepc_q     <= mepc_d;
      mcause_q   <= mcause_d;
    end
  end

  assign mtvec_out = mtvec_q;
  assign mepc_out  = mepc_q;
  assign mie_out   = mie_q;

endmodule

// File: tb/tb_csr_unit.sv
`timescale 1ns/1ps
module tb_csr_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        trap_entry;
  logic [31:0] trap_pc;
  logic [3:0]  mcause_in;
  logic        mret_sig;
  logic        csr_we;
  logic [1:0]  csr_op;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic        instr_retire;
  logic [31:0] csr_rdata;
  logic [31:0] mtvec_out;
  logic [31:0] mepc_out;
  logic        mie_out;
  logic        csr_illegal;

  int checks = 0;
  int errors = 0;

  csr_unit dut (
    .clk(clk), .rst(rst), .trap_entry(trap_entry), .trap_pc(trap_pc),
    .mcause_in(mcause_in), .mret_sig(mret_sig), .csr_we(csr_we),
    .csr_op(csr_op), .csr_addr(csr_addr), .csr_wdata(csr_wdata),
    .instr_retire(instr_retire), .csr_rdata(csr_rdata),
    .mtvec_out(mtvec_out), .mepc_out(mepc_out), .mie_out(mie_out),
    .csr_illegal(csr_illegal)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Inputs change 1ns after the rising edge; outputs sampled before the next edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [11:0] a);
    csr_we   = 1'b0;
    csr_op   = 2'b00;
    csr_addr = a;
    #1;
  endtask

  task automatic wr(input logic [1:0] op, input logic [11:0] a, input logic [31:0] d);
    csr_we    = 1'b1;
    csr_op    = op;
    csr_addr  = a;
    csr_wdata = d;
    tick();
    csr_we = 1'b0;
    csr_op = 2'b00;
  endtask

  task automatic test_reset();
    rst = 1'b1; trap_entry = 0; trap_pc = 0; mcause_in = 0; mret_sig = 0;
    csr_we = 0; csr_op = 0; csr_addr = 0; csr_wdata = 0; instr_retire = 0;
    tick(); tick();
    checks++; if (mtvec_out !== 32'h100) begin errors++; $display("FAIL rst_mtvec_out got %h exp %h", mtvec_out, 32'h100); end
    checks++; if (mepc_out !== 32'h0) begin errors++; $display("FAIL rst_mepc_out got %h exp 0", mepc_out); end
    checks++; if (mie_out !== 1'b0) begin errors++; $display("FAIL rst_mie_out got %b exp 0", mie_out); end
    rst = 1'b0;
    tick();
    rd(12'h305);
    checks++; if (csr_rdata !== 32'h0000_0100) begin errors++; $display("FAIL rst_rd_mtvec got %h exp %h", csr_rdata, 32'h100); end
    rd(12'h300);
    checks++; if (csr_rdata !== 32'h0000_1800) begin errors++; $display("FAIL rst_rd_mstatus got %h exp %h", csr_rdata, 32'h1800); end
    rd(12'h342);
    checks++; if (csr_rdata !== 32'h0) begin errors++; $display("FAIL rst_rd_mcause got %h exp 0", csr_rdata); end
    rd(12'h340);
    checks++; if (csr_rdata !== 32'h0) begin errors++; $display("FAIL rst_rd_mscratch got %h exp 0", csr_rdata); end
    checks++; if (csr_illegal !== 1'b0) begin errors++; $display("FAIL rst_illegal got %b exp 0", csr_illegal); end
  endtask

  task automatic test_trap();
    wr(2'b10, 12'h300, 32'h8);
    rd(12'h300);
    checks++; if (csr_rdata !== 32'h1808) begin errors++; $display("FAIL trap_set_mie got %h exp %h", csr_rdata, 32'h1808); end
    checks++; if (mie_out !== 1'b1) begin errors++; $display("FAIL trap_mie_out_pre got %b exp 1", mie_out); end
    trap_entry = 1'b1; trap_pc = 32'h0000_0046; mcause_in = 4'd11;
    #1;
    checks++; if (mepc_out !== 32'h0) begin errors++; $display("FAIL trap_no_forward got %h exp 0", mepc_out); end
    tick();
    trap_entry = 1'b0;
    checks++; if (mepc_out !== 32'h44) begin errors++; $display("FAIL trap_mepc_out got %h exp %h", mepc_out, 32'h44); end
    checks++; if (mie_out !== 1'b0) begin errors++; $display("FAIL trap_mie_out got %b exp 0", mie_out); end
    rd(12'h342);
    checks++; if (csr_rdata !== 32'hB) begin errors++; $display("FAIL trap_mcause got %h exp %h", csr_rdata, 32'hB); end
    rd(12'h300);
    checks++; if (csr_rdata !== 32'h1880) begin errors++; $display("FAIL trap_mstatus got %h exp %h", csr_rdata, 32'h1880); end
  endtask

  task automatic test_mret_priority();
    mret_sig = 1'b1;
    tick();
    mret_sig = 1'b0;
    checks++; if (mie_out !== 1'b1) begin errors++; $display("FAIL mret_mie_out got %b exp 1", mie_out); end
    rd(12'h300);
    checks++; if (csr_rdata !== 32'h1888) begin errors++; $display("FAIL mret_mstatus got %h exp %h", csr_rdata, 32'h1888); end
    // trap + mret + write together: trap wins
    trap_entry = 1'b1; trap_pc = 32'h0000_2003; mcause_in = 4'd3; mret_sig = 1'b1;
    csr_we = 1'b1; csr_op = 2'b01; csr_addr = 12'h341; csr_wdata = 32'hDEAD_BEEF;
    tick();
    trap_entry = 1'b0; mret_sig = 1'b0; csr_we = 1'b0; csr_op = 2'b00;
    checks++; if (mepc_out !== 32'h2000) begin errors++; $display("FAIL prio_trap_mepc got %h exp %h", mepc_out, 32'h2000); end
    rd(12'h342);
    checks++; if (csr_rdata !== 32'h3) begin errors++; $display("FAIL prio_trap_mcause got %h exp 3", csr_rdata); end
    rd(12'h300);
    checks++; if (csr_rdata !== 32'h1880) begin errors++; $display("FAIL prio_trap_mstatus got %h exp %h", csr_rdata, 32'h1880); end
    // mret + write together: mret wins, write dropped
    mret_sig = 1'b1;
    csr_we = 1'b1; csr_op = 2'b01; csr_addr = 12'h340; csr_wdata = 32'h1234_5678;
    tick();
    mret_sig = 1'b0; csr_we = 1'b0; csr_op = 2'b00;
    rd(12'h340);
    checks++; if (csr_rdata !== 32'h0) begin errors++; $display("FAIL prio_mret_drop_write got %h exp 0", csr_rdata); end
    rd(12'h300);
    checks++; if (csr_rdata !== 32'h1888) begin errors++; $display("FAIL prio_mret_mstatus got %h exp %h", csr_rdata, 32'h1888); end
  endtask

  task automatic test_rw_ops();
    wr(2'b01, 12'h340, 32'hF0F0_F0F0);
    rd(12'h340);
    checks++; if (csr_rdata !== 32'hF0F0_F0F0) begin errors++; $display("FAIL rw_mscratch got %h exp %h", csr_rdata, 32'hF0F0_F0F0); end
    wr(2'b11, 12'h340, 32'h0000_00F0);
    rd(12'h340);
    checks++; if (csr_rdata !== 32'hF0F0_F000) begin errors++; $display("FAIL rc_mscratch got %h exp %h", csr_rdata, 32'hF0F0_F000); end
    wr(2'b10, 12'h340, 32'h0F00_0000);
    rd(12'h340);
    checks++; if (csr_rdata !== 32'hFFF0_F000) begin errors++; $display("FAIL rs_mscratch got %h exp %h", csr_rdata, 32'hFFF0_F000); end
    // op 00 with strobe: no write
    wr(2'b00, 12'h340, 32'h0);
    rd(12'h340);
    checks++; if (csr_rdata !== 32'hFFF0_F000) begin errors++; $display("FAIL op_none_nowrite got %h exp %h", csr_rdata, 32'hFFF0_F000); end
    // mtvec: low bits forced, no same-cycle forwarding
    csr_we = 1'b1; csr_op = 2'b01; csr_addr = 12'h305; csr_wdata = 32'h0000_1237;
    #1;
    checks++; if (mtvec_out !== 32'h100) begin errors++; $display("FAIL mtvec_no_forward got %h exp %h", mtvec_out, 32'h100); end
    tick();
    csr_we = 1'b0; csr_op = 2'b00;
    checks++; if (mtvec_out !== 32'h1234) begin errors++; $display("FAIL mtvec_write got %h exp %h", mtvec_out, 32'h1234); end
    wr(2'b01, 12'h341, 32'hDEAD_BEEF);
    checks++; if (mepc_out !== 32'hDEAD_BEEC) begin errors++; $display("FAIL mepc_write got %h exp %h", mepc_out, 32'hDEAD_BEEC); end
    wr(2'b01, 12'h342, 32'hFFFF_FFFF);
    rd(12'h342);
    checks++; if (csr_rdata !== 32'hF) begin errors++; $display("FAIL mcause_write got %h exp %h", csr_rdata, 32'hF); end
    wr(2'b01, 12'h300, 32'hFFFF_FFFF);
    rd(12'h300);
    checks++; if (csr_rdata !== 32'h1888) begin errors++; $display("FAIL mstatus_rw_all got %h exp %h", csr_rdata, 32'h1888); end
    wr(2'b11, 12'h300, 32'h88);
    rd(12'h300);
    checks++; if (csr_rdata !== 32'h1800) begin errors++; $display("FAIL mstatus_rc got %h exp %h", csr_rdata, 32'h1800); end
  endtask

  task automatic test_illegal();
    csr_we = 1'b1; csr_op = 2'b01; csr_addr = 12'hF14; csr_wdata = 32'h5;
    #1;
    checks++; if (csr_illegal !== 1'b1) begin errors++; $display("FAIL ill_mhartid_rw got %b exp 1", csr_illegal); end
    tick();
    csr_op = 2'b00;
    #1;
    checks++; if (csr_illegal !== 1'b0) begin errors++; $display("FAIL ill_mhartid_read got %b exp 0", csr_illegal); end
    checks++; if (csr_rdata !== 32'h0) begin errors++; $display("FAIL mhartid_value got %h exp 0", csr_rdata); end
    csr_op = 2'b10; csr_addr = 12'h7C0; csr_wdata = 32'hFFFF_FFFF;
    #1;
    checks++; if (csr_illegal !== 1'b1) begin errors++; $display("FAIL ill_unmapped_rs got %b exp 1", csr_illegal); end
    tick();
    csr_op = 2'b00;
    #1;
    checks++; if (csr_illegal !== 1'b1) begin errors++; $display("FAIL ill_unmapped_none got %b exp 1", csr_illegal); end
    csr_we = 1'b0;
    #1;
    checks++; if (csr_illegal !== 1'b0) begin errors++; $display("FAIL ill_no_strobe got %b exp 0", csr_illegal); end
    checks++; if (csr_rdata !== 32'h0) begin errors++; $display("FAIL unmapped_read got %h exp 0", csr_rdata); end
    rd(12'h340);
    checks++; if (csr_rdata !== 32'hFFF0_F000) begin errors++; $display("FAIL ill_no_state_change got %h exp %h", csr_rdata, 32'hFFF0_F000); end
    checks++; if (mtvec_out !== 32'h1234) begin errors++; $display("FAIL ill_mtvec_kept got %h exp %h", mtvec_out, 32'h1234); end
  endtask

  task automatic test_counters();
`ifdef CSR_COUNTERS_EN
    wr(2'b01, 12'hB00, 32'hFFFF_FFFE);
    wr(2'b01, 12'hB80, 32'hFFFF_FFFF);
    rd(12'hB00);
    checks++; if (csr_rdata !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mcycle_lo_pre got %h exp %h", csr_rdata, 32'hFFFF_FFFF); end
    rd(12'hB80);
    checks++; if (csr_rdata !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mcycle_hi_pre got %h exp %h", csr_rdata, 32'hFFFF_FFFF); end
    tick();
    rd(12'hB00);
    checks++; if (csr_rdata !== 32'h0) begin errors++; $display("FAIL mcycle_wrap_lo got %h exp 0", csr_rdata); end
    rd(12'hB80);
    checks++; if (csr_rdata !== 32'h0) begin errors++; $display("FAIL mcycle_wrap_hi got %h exp 0", csr_rdata); end
    tick();
    rd(12'hB00);
    checks++; if (csr_rdata !== 32'h1) begin errors++; $display("FAIL mcycle_incr got %h exp 1", csr_rdata); end
    wr(2'b01, 12'hB02, 32'h0);
    for (int i = 0; i < 5; i++) begin
      instr_retire = 1'b1; tick();
      instr_retire = 1'b0; tick();
    end
    rd(12'hB02);
    checks++; if (csr_rdata !== 32'h5) begin errors++; $display("FAIL minstret_lo got %h exp 5", csr_rdata); end
    rd(12'hB82);
    checks++; if (csr_rdata !== 32'h0) begin errors++; $display("FAIL minstret_hi got %h exp 0", csr_rdata); end
`else
    for (int i = 0; i < 3; i++) begin
      instr_retire = 1'b1; tick();
    end
    instr_retire = 1'b0;
    rd(12'hB00);
    checks++; if (csr_rdata !== 32'h0) begin errors++; $display("FAIL nocnt_read got %h exp 0", csr_rdata); end
    csr_we = 1'b1;
    #1;
    checks++; if (csr_illegal !== 1'b1) begin errors++; $display("FAIL nocnt_illegal got %b exp 1", csr_illegal); end
    csr_addr = 12'hB82;
    #1;
    checks++; if (csr_rdata !== 32'h0) begin errors++; $display("FAIL nocnt_minstreth_read got %h exp 0", csr_rdata); end
    checks++; if (csr_illegal !== 1'b1) begin errors++; $display("FAIL nocnt_minstreth_illegal got %b exp 1", csr_illegal); end
    csr_we = 1'b0;
    tick();
`endif
  endtask

  task automatic test_async_reset();
    wr(2'b10, 12'h300, 32'h8);
    checks++; if (mie_out !== 1'b1) begin errors++; $display("FAIL arst_pre_mie got %b exp 1", mie_out); end
    trap_entry = 1'b1; trap_pc = 32'h0000_0080; mcause_in = 4'd4; mret_sig = 1'b1;
    csr_we = 1'b1; csr_op = 2'b01; csr_addr = 12'h340; csr_wdata = 32'h1;
    rst = 1'b1;
    #1;
    checks++; if (mie_out !== 1'b0) begin errors++; $display("FAIL arst_async_mie got %b exp 0", mie_out); end
    checks++; if (mtvec_out !== 32'h100) begin errors++; $display("FAIL arst_async_mtvec got %h exp %h", mtvec_out, 32'h100); end
    tick();
    checks++; if (mepc_out !== 32'h0) begin errors++; $display("FAIL arst_no_trap_save got %h exp 0", mepc_out); end
    trap_entry = 1'b0; mret_sig = 1'b0; csr_we = 1'b0; csr_op = 2'b00;
    rst = 1'b0;
    tick();
    rd(12'h340);
    checks++; if (csr_rdata !== 32'h0) begin errors++; $display("FAIL arst_mscratch got %h exp 0", csr_rdata); end
    rd(12'h300);
    checks++; if (csr_rdata !== 32'h1800) begin errors++; $display("FAIL arst_mstatus got %h exp %h", csr_rdata, 32'h1800); end
    rd(12'h342);
    checks++; if (csr_rdata !== 32'h0) begin errors++; $display("FAIL arst_mcause got %h exp 0", csr_rdata); end
  endtask

  initial begin
    test_reset();
    test_trap();
    test_mret_priority();
    test_rw_ops();
    test_illegal();
    test_counters();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
